// File: rtl/fibo.sv
// Iterative Fibonacci engine: fib(i) modulo 2^FW,
// computed by a three-state Moore FSM.
module fibo #(
  parameter int IW = 5,
  parameter int FW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] i,
  output logic          ready,
  output logic          done_tick,
  output logic [FW-1:0] f
);

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] t0, t0_nxt;
  logic [FW-1:0] t1, t1_nxt;
  logic [IW-1:0] n, n_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t0    <= '0;
      t1    <= '0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      t0    <= t0_nxt;
      t1    <= t1_nxt;
      n     <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t0_nxt    = t0;
    t1_nxt    = t1;
    n_nxt     = n;
    ready     = 1'b0;
    done_tick = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          t0_nxt    = '0;
          t1_nxt    = FW'(1);
          n_nxt     = i;
          state_nxt = OP;
        end
      end
      OP: begin
        if (n == '0) begin
          t1_nxt    = '0;
          state_nxt = DONE;
        end else if (n == IW'(1)) begin
          state_nxt = DONE;
        end else begin
          // sum wraps modulo 2^FW by construction
          t1_nxt = t1 + t0;
          t0_nxt = t1;
          n_nxt  = n - IW'(1);
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign f = t1;

endmodule

// File: tb/tb_fibo.sv
// Directed scoreboard bench for fibo: results queued at start,
// popped and compared on done_tick.
module tb_fibo;

  localparam int IW = 5;
  localparam int FW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] i = '0;
  logic          ready;
  logic          done_tick;
  logic [FW-1:0] f;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int ops;

  fibo #(.IW(IW), .FW(FW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .i(i),
    .ready(ready),
    .done_tick(done_tick),
    .f(f)
  );

  always #5 clk = ~clk;

  function automatic int fib_mod(input int n);
    logic [FW-1:0] a, b, t;
    a = '0;
    b = FW'(1);
    for (int k = 1; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (n == 0) ? 0 : int'(b);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // entered at the first OP negedge; counts cycles until done_tick
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done_tick !== 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 200) check("timeout", cnt, -1);
  endtask

  task automatic pop_check(input string tag);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check(tag, int'(f), e);
  endtask

  task automatic run(input int idx, input int exp_ops, input string tag);
    @(negedge clk);
    check({tag, "_ready_pre"}, int'(ready), 1);
    start = 1'b1;
    i = IW'(idx);
    exp_q.push_back(fib_mod(idx));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready_op"}, int'(ready), 0);
    wait_done(ops);
    check({tag, "_ops"}, ops, exp_ops);
    check({tag, "_done"}, int'(done_tick), 1);
    pop_check({tag, "_f"});
    @(negedge clk);
    check({tag, "_done_off"}, int'(done_tick), 0);
    check({tag, "_ready_post"}, int'(ready), 1);
  endtask

  initial begin
    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done_tick), 0);
    check("rst_f", int'(f), 0);
    @(negedge clk);
    rst = 1'b1;

    // start held high: back-to-back passes with one IDLE cycle between
    @(negedge clk);
    check("hold_ready0", int'(ready), 1);
    start = 1'b1;
    i = IW'(5);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(5);
      @(negedge clk);
      wait_done(ops);
      check("hold_ops", ops, 5);
      pop_check("hold_f");
      @(negedge clk);
      check("hold_ready", int'(ready), 1);
    end
    start = 1'b0;

    run(0, 1, "i0");
    run(1, 1, "i1");
    run(2, 2, "i2");
    run(5, 5, "i5");
    run(30, 30, "i30");
    check("i30_const", int'(f), 832040);
    run(31, 31, "i31");
    check("i31_const", int'(f), 297693);

    // start and i churn while OP is busy
    @(negedge clk);
    start = 1'b1;
    i = IW'(10);
    exp_q.push_back(55);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("busy_ready", int'(ready), 0);
      i = IW'(3 + k);
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(ops);
    check("busy_ops", ops + 3, 10);
    pop_check("busy_f");
    @(negedge clk);
    check("busy_ready_post", int'(ready), 1);

    // asynchronous abort mid-OP
    @(negedge clk);
    start = 1'b1;
    i = IW'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_f", int'(f), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done_tick), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_done", int'(done_tick), 0);
    end
    rst = 1'b1;
    run(7, 7, "i7");
    check("i7_const", int'(f), 13);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
